// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Single-cycle logic/arith/shift ops plus a 32-step
// shift-add multiplier. All outputs are registered; reset is synchronous.
module alu_exec_unit (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [5:0]  i_alu_control,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [4:0]  i_shamt,
   input  logic        i_start,
   output logic [31:0] o_result,
   output logic        o_zero,
   output logic        o_neg,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [5:0] OP_ADD  = 6'b100000;
   localparam logic [5:0] OP_SUB  = 6'b100010;
   localparam logic [5:0] OP_MUL  = 6'b011000;
   localparam logic [5:0] OP_AND  = 6'b100100;
   localparam logic [5:0] OP_OR   = 6'b100101;
   localparam logic [5:0] OP_NOR  = 6'b100111;
   localparam logic [5:0] OP_XOR  = 6'b100110;
   localparam logic [5:0] OP_SLL  = 6'b000000;
   localparam logic [5:0] OP_SRL  = 6'b000010;
   localparam logic [5:0] OP_SLT  = 6'b101010;
   localparam logic [5:0] OP_BCMP = 6'b000001;
   localparam logic [5:0] OP_AD0  = 6'b101000;
   localparam logic [5:0] OP_AD1  = 6'b101001;
   localparam logic [5:0] OP_AD2  = 6'b100001;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MULT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_result;
   logic        r_zero;
   logic        r_neg;
   logic        r_done;
   logic [31:0] r_mcand;
   logic [31:0] r_mplier;
   logic [31:0] r_acc;
   logic [4:0]  r_count;
   logic [31:0] w_alu_res;
   logic [31:0] w_step_acc;
   logic        w_is_mul;
   logic        w_last;

   // Single-cycle result; unknown codes fall through to zero.
   always_comb begin
      w_alu_res = 32'd0;
      case (i_alu_control)
         OP_ADD, OP_AD0, OP_AD1, OP_AD2: w_alu_res = i_a + i_b;
         OP_SUB, OP_BCMP:                w_alu_res = i_a - i_b;
         OP_AND:                         w_alu_res = i_a & i_b;
         OP_OR:                          w_alu_res = i_a | i_b;
         OP_NOR:                         w_alu_res = ~(i_a | i_b);
         OP_XOR:                         w_alu_res = i_a ^ i_b;
         OP_SLL:                         w_alu_res = i_b << i_shamt;
         OP_SRL:                         w_alu_res = i_b >> i_shamt;
         OP_SLT:                         w_alu_res = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
         default:                        w_alu_res = 32'd0;
      endcase
   end

   assign w_is_mul   = (i_alu_control == OP_MUL);
   assign w_step_acc = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
   // Counter reads 31 during the 32nd step, so that step also retires the product.
   assign w_last     = (r_count == 5'd31);

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_start && w_is_mul) begin
               w_next_state = ST_MULT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_MULT: begin
            if (w_last) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_MULT;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath: result/flag registers and the shift-add multiplier.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_result <= 32'd0;
         r_zero   <= 1'b1;
         r_neg    <= 1'b0;
         r_done   <= 1'b0;
         r_mcand  <= 32'd0;
         r_mplier <= 32'd0;
         r_acc    <= 32'd0;
         r_count  <= 5'd0;
      end else begin
         r_done <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (i_start) begin
               if (w_is_mul) begin
                  r_mcand  <= i_a;
                  r_mplier <= i_b;
                  r_acc    <= 32'd0;
                  r_count  <= 5'd0;
               end else begin
                  r_result <= w_alu_res;
                  r_zero   <= (w_alu_res == 32'd0);
                  r_neg    <= w_alu_res[31];
                  r_done   <= 1'b1;
               end
            end
         end else begin
            r_acc    <= w_step_acc;
            r_mcand  <= {r_mcand[30:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_count  <= r_count + 5'd1;
            if (w_last) begin
               r_result <= w_step_acc;
               r_zero   <= (w_step_acc == 32'd0);
               r_neg    <= w_step_acc[31];
               r_done   <= 1'b1;
            end
         end
      end
   end

   assign o_result = r_result;
   assign o_zero   = r_zero;
   assign o_neg    = r_neg;
   assign o_done   = r_done;
   assign o_busy   = (r_state == ST_MULT);

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 ALUControl  input  6  operation code produced by the ALU control stage (encodings in REQ-010).
REQ-004 A  input  32  operand A (rs).
REQ-005 B  input  32  operand B (rt or sign-extended immediate).
REQ-006 Shamt  input  5  shift amount for SLL/SRL.
REQ-007 Start  input  1  request strobe; operands and ALUControl sampled when Start=1 and unit idle.
REQ-008 Result  output  32  registered result; holds value until next completed operation.
REQ-009 Zero  output  1  registered, 1 when Result==0; Neg  output  1  registered Result[31]; Busy  output  1  high while multiply in progress; Done  output  1  one-cycle completion pulse.

Function
REQ-010 Encodings SHALL be: 100000 ADD (A+B); 100010 SUB (A-B); 011000 MUL (low 32 bits of A*B); 100100 AND; 100101 OR; 100111 NOR; 100110 XOR; 000000 SLL (B<<Shamt); 000010 SRL (B>>Shamt, logical); 101010 SLT (1 if signed A<B, else 0); 000001 branch compare (A-B); 101000/101001/100001 address add (A+B).
REQ-011 Any other ALUControl value SHALL complete as a single-cycle op with Result=0, Zero=1, Neg=0.
REQ-012 ADD/SUB/address/compare SHALL use 32-bit wrap-around arithmetic; no overflow flag, no trap.
REQ-013 State machine SHALL have two states: IDLE and MULT; reset state IDLE.
REQ-014 Single-cycle op: at edge E0 with Start=1 in IDLE, Result/Zero/Neg SHALL update at E0 and Done SHALL be 1 for exactly the cycle after E0; state stays IDLE.
REQ-015 MUL: at edge E0 with Start=1 in IDLE, unit SHALL latch A as multiplicand, B as multiplier, clear accumulator and 5-bit iteration counter, enter MULT.
REQ-016 In MULT each edge SHALL perform one shift-add step: if multiplier[0] then acc+=multiplicand (mod 2^32); multiplicand<<=1; multiplier>>=1 (logical); counter++.
REQ-017 Exactly 32 steps SHALL run (E1..E32), no early termination; at E32 Result=acc, Zero/Neg updated, state IDLE, Done=1 for the cycle after E32.
REQ-018 Busy SHALL be 1 for exactly the 32 cycles following E0..E31 and 0 otherwise; Busy and Done never both 1.
REQ-019 Result/Zero/Neg SHALL NOT change during MULT (previous result held until E32).
REQ-020 Start while in MULT SHALL be ignored (no queuing); operand/ALUControl changes during MULT SHALL not affect the product.
REQ-021 Start in the cycle Done=1 SHALL be accepted (unit is IDLE), enabling back-to-back operations.
REQ-022 Signed MUL operands SHALL produce the correct two's-complement low 32 bits (inherent to mod-2^32 shift-add).

Reset
REQ-023 Reset=1 at any edge SHALL force IDLE, Result=0, Zero=1, Neg=0, Busy=0, Done=0, clear counter/accumulator; takes priority over Start.
REQ-024 Reset during MULT SHALL abort the multiply with no Done pulse; Start with Reset=1 SHALL be discarded.

Verification
REQ-025 ADD A=0x7FFFFFFF, B=1, Start one cycle -> next cycle Result=0x80000000, Neg=1, Zero=0, Done=1 for one cycle, Busy=0.
REQ-026 MUL A=7, B=0xFFFFFFFD (-3) -> Busy high 32 cycles, Done after E32, Result=0xFFFFFFEB, Neg=1; Result unchanged during Busy.
REQ-027 MUL in progress, Start with SUB at cycle 10 -> ignored; MUL completes normally at E32, no extra Done.
REQ-028 Reset asserted at E15 of a MUL -> Busy=0, Result=0, Zero=1, no Done; subsequent SLT A=0xFFFFFFFF, B=1 -> Result=1.
REQ-029 SRL B=0x80000000, Shamt=31 -> Result=1; SLL B=1, Shamt=31 -> Result=0x80000000; compare 000001 A=B=5 -> Result=0, Zero=1.
REQ-030 Back-to-back: MUL 0x10000*0x10000 then Start XOR in Done cycle -> MUL Result=0 Zero=1, XOR completes one cycle later; unknown code 111111 -> Result=0, Done=1.
